booth_mul_seq: RTL

Sequential radix-4 (bit-pair recoded) Booth multiplier for the datapath ALU's multiply path. It takes two signed 32-bit operands, which in the datapath come from the Y register and the bus. It produces a 64-bit signed product that feeds the Z register, so ZHIout/ZLOout can later move the halves into HI and LO. A start/busy/done handshake lets the control sequencer hold the Zin step until the product is ready.

---
 rtl/booth_mul_seq_if.sv | 22 ++
 rtl/booth_mul_seq.sv | 111 +++++++++++
 2 files changed

// File: rtl/booth_mul_seq_if.sv
// Handshake and operand/result bundle for the sequential Booth multiplier.
interface booth_mul_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] multiplicand;
  logic [WIDTH-1:0] multiplier;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] product_hi;
  logic [WIDTH-1:0] product_lo;

  modport master (
    output start, multiplicand, multiplier,
    input  busy, done, product_hi, product_lo
  );

  modport slave (
    input  start, multiplicand, multiplier,
    output busy, done, product_hi, product_lo
  );
endinterface

// File: rtl/booth_mul_seq.sv
// Sequential radix-4 Booth multiplier: one recoded bit-pair per clock,
// WIDTH/2 iterations, signed WIDTH x WIDTH -> 2*WIDTH product.
//
// state | meaning
// IDLE  | waiting for start; product registers hold last result
// RUN   | one bit-pair iteration per cycle, busy=1
// DONE  | single-cycle done pulse; a start here begins the next multiply
//
// WIDTH must be even and at least 4.
module booth_mul_seq #(
  parameter int WIDTH = 32
) (
  input  logic          Clock,
  input  logic          Clear,
  booth_mul_seq_if.slave bus
);

  localparam int AW = WIDTH + 2;
  localparam int CW = $clog2(WIDTH / 2);
  localparam logic [CW-1:0] LAST = CW'(WIDTH / 2 - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [AW-1:0]    a;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] m;
  logic             q_m1;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] prod_hi;
  logic [WIDTH-1:0] prod_lo;

  logic [AW-1:0]    m_ext;
  logic [AW-1:0]    m_dbl;
  logic [AW-1:0]    addend;
  logic [AW-1:0]    sum;
  logic [AW-1:0]    a_sh;
  logic [WIDTH-1:0] q_sh;
  logic             accept;

  // DONE leaves unconditionally; a start seen there is taken immediately so
  // back-to-back multiplies run every WIDTH/2+1 cycles.
  assign accept = bus.start && (state == IDLE || state == DONE);

  // State register
  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (count == LAST) state_nxt = DONE;
      DONE:    state_nxt = bus.start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Booth recoding, add, and 2-bit arithmetic shift of {A,Q,q_m1}
  always_comb begin
    m_ext = {{2{m[WIDTH-1]}}, m};
    m_dbl = {m_ext[AW-2:0], 1'b0};
    case ({q[1:0], q_m1})
      3'b001, 3'b010: addend = m_ext;
      3'b011:         addend = m_dbl;
      3'b100:         addend = -m_dbl;
      3'b101, 3'b110: addend = -m_ext;
      default:        addend = '0;
    endcase
    sum  = a + addend;
    a_sh = {{2{sum[AW-1]}}, sum[AW-1:2]};
    q_sh = {sum[1:0], q[WIDTH-1:2]};
  end

  // Iteration datapath and result capture on the last iteration
  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      a       <= '0;
      q       <= '0;
      m       <= '0;
      q_m1    <= 1'b0;
      count   <= '0;
      prod_hi <= '0;
      prod_lo <= '0;
    end else if (accept) begin
      a     <= '0;
      q     <= bus.multiplier;
      m     <= bus.multiplicand;
      q_m1  <= 1'b0;
      count <= '0;
    end else if (state == RUN) begin
      a     <= a_sh;
      q     <= q_sh;
      q_m1  <= q[1];
      count <= count + 1'b1;
      if (count == LAST) begin
        prod_hi <= a_sh[WIDTH-1:0];
        prod_lo <= q_sh;
      end
    end
  end

  assign bus.busy       = (state == RUN);
  assign bus.done       = (state == DONE);
  assign bus.product_hi = prod_hi;
  assign bus.product_lo = prod_lo;

endmodule
